// File: rtl/cam_clk_power_seq.sv
// cam_clk_power_seq: qualifies PLL lock, then sequences OV7670 XCLK/PWDN/RESET# bring-up.
// Revision: 1.0
`default_nettype none

module cam_clk_power_seq #(
   parameter int LOCK_QUAL_CYCLES = 1024,
   parameter int PWDN_CYCLES      = 2400,
   parameter int RST_CYCLES       = 2400,
   parameter int SETTLE_CYCLES    = 24000,
   parameter int CNT_W            = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_lock,
   output logic       xclk_en,
   output logic       cam_pwdn,
   output logic       cam_reset_n,
   output logic       sys_reset,
   output logic       ready,
   output logic [7:0] relock_count,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      LOCK_QUAL = 3'd1,
      PWDN      = 3'd2,
      CAM_RST   = 3'd3,
      SETTLE    = 3'd4,
      READY     = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] LQ_LOAD  = CNT_W'(LOCK_QUAL_CYCLES - 1);
   localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(PWDN_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] ST_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

   state_t           cur;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       sync;
   logic             lock_s;

   assign lock_s = sync[1];
   assign state  = cur;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync         <= 2'b00;
         cur          <= WAIT_LOCK;
         cnt          <= '0;
         relock_count <= 8'd0;
         xclk_en      <= 1'b0;
         cam_pwdn     <= 1'b1;
         cam_reset_n  <= 1'b0;
         sys_reset    <= 1'b1;
         ready        <= 1'b0;
      end else begin
         sync <= {sync[0], pll_lock};

         // Pin outputs follow the state register one cycle later.
         xclk_en     <= (cur != WAIT_LOCK) && (cur != LOCK_QUAL);
         cam_pwdn    <= (cur == WAIT_LOCK) || (cur == LOCK_QUAL) || (cur == PWDN);
         cam_reset_n <= (cur == SETTLE) || (cur == READY);
         sys_reset   <= (cur != READY);
         ready       <= (cur == READY);

         // Lock loss wins over any phase expiry in the same cycle.
         if (cur != WAIT_LOCK && !lock_s) begin
            cur <= WAIT_LOCK;
            cnt <= '0;
            if (relock_count != 8'hFF)
               relock_count <= relock_count + 8'd1;
         end else begin
            case (cur)
               WAIT_LOCK: begin
                  if (lock_s) begin
                     cur <= LOCK_QUAL;
                     cnt <= LQ_LOAD;
                  end
               end
               LOCK_QUAL: begin
                  if (cnt == '0) begin
                     cur <= PWDN;
                     cnt <= PW_LOAD;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               PWDN: begin
                  if (cnt == '0) begin
                     cur <= CAM_RST;
                     cnt <= RST_LOAD;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               CAM_RST: begin
                  if (cnt == '0) begin
                     cur <= SETTLE;
                     cnt <= ST_LOAD;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               SETTLE: begin
                  if (cnt == '0) begin
                     cur <= READY;
                     cnt <= '0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               READY:   cur <= READY;
               default: cur <= WAIT_LOCK;
            endcase
         end
      end
   end

endmodule

`default_nettype wire
